pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline. It takes the load-use stall request from the hazard detection unit, the EX-stage taken-branch signal and the data-memory handshake. It resolves them by fixed priority into per-stage write-enable, bubble and flush controls. It also tracks multi-cycle memory waits, with a timeout that halts the core.

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/sat_counter.sv | 19 +
 rtl/pipeline_stall_controller.sv | 133 +++++++++++++
 tb/tb_pipeline_stall_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer:
// FSM state encoding, default memory timeout and the per-stage control bundle.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } pipe_state_e;

  localparam int MEM_TIMEOUT_DEFAULT = 16;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic stage_hold;
  } pipe_ctrl_t;

  // Canonical control patterns, one per resolved pipeline condition.
  localparam pipe_ctrl_t CTRL_IDLE  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_HOLD  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam pipe_ctrl_t CTRL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam pipe_ctrl_t CTRL_STALL = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc cycles and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline with memory-wait timeout.
// Optional feature macro: PIPE_PERF_CNT_EN builds the saturating performance counters.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_stall,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             stage_hold,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] memwait_cycles
);

  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  pipe_state_e       state_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              halt_q;
  logic              frz;
  pipe_ctrl_t        ctrl;

  assign frz = dmem_req & ~dmem_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (!rst_n) begin
      ctrl = CTRL_IDLE;
    end else if (state_q == ST_HALT) begin
      ctrl = CTRL_HOLD;
    end else if (frz) begin
      // EX and ID are held, so branch/load-use requests persist to the release cycle.
      ctrl = CTRL_HOLD;
    end else if (branch_taken) begin
      ctrl = CTRL_FLUSH;
    end else if (load_use_stall) begin
      ctrl = CTRL_STALL;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign stage_hold  = ctrl.stage_hold;
  assign halt        = halt_q;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      wait_cnt <= '0;
      halt_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (frz) begin
            state_q  <= ST_MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          // A ready arriving in the timeout cycle releases rather than halts.
          if (!frz) begin
            state_q  <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state_q <= ST_HALT;
            halt_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q  <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc;
  logic flush_inc;
  logic memwait_inc;

  assign stall_inc   = ctrl.idex_bubble & ~ctrl.ifid_flush;
  assign flush_inc   = ctrl.ifid_flush;
  assign memwait_inc = frz & (state_q != ST_HALT);

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_memwait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (memwait_inc),
    .count (memwait_cycles)
  );
`else
  assign stall_cycles   = '0;
  assign flush_count    = '0;
  assign memwait_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller against a cycle-level
// behavioural model that counts consecutive frozen cycles.
module tb_pipeline_stall_controller;

  localparam int TO    = 4;
  localparam int CNT_W = 32;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             lus, br, req, rdy;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, stage_hold, halt;
  logic [CNT_W-1:0] stall_cycles, flush_count, memwait_cycles;
  logic [4:0]       dut_ctrl;

  int errors = 0;
  int checks = 0;

  bit               m_halted;
  int               m_frz_run;
  logic [CNT_W-1:0] m_stall, m_flush, m_memwait;

  pipeline_stall_controller #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_use_stall (lus),
    .branch_taken   (br),
    .dmem_req       (req),
    .dmem_ready     (rdy),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .stage_hold     (stage_hold),
    .halt           (halt),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count),
    .memwait_cycles (memwait_cycles)
  );

  assign dut_ctrl = {pc_write, ifid_write, ifid_flush, idex_bubble, stage_hold};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Expected {pc_write, ifid_write, ifid_flush, idex_bubble, stage_hold, halt}.
  function automatic logic [5:0] exp_out();
    if (m_halted)          return {5'b00001, 1'b1};
    if (req && !rdy)       return {5'b00001, 1'b0};
    if (br)                return {5'b11110, 1'b0};
    if (lus)               return {5'b00010, 1'b0};
    return {5'b11000, 1'b0};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Advance the model across the coming rising edge using the current inputs.
  task automatic model_step();
    if (!m_halted) begin
      if (req && !rdy) begin
        if (PERF) m_memwait = sat_inc(m_memwait);
        m_frz_run++;
        if (m_frz_run == TO) m_halted = 1'b1;
      end else begin
        m_frz_run = 0;
        if (br)       begin if (PERF) m_flush = sat_inc(m_flush); end
        else if (lus) begin if (PERF) m_stall = sat_inc(m_stall); end
      end
    end
  endtask

  task automatic model_reset();
    m_halted  = 1'b0;
    m_frz_run = 0;
    m_stall   = '0;
    m_flush   = '0;
    m_memwait = '0;
  endtask

  task automatic drive(input logic l, input logic b, input logic q, input logic r);
    @(negedge clk);
    lus = l; br = b; req = q; rdy = r;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    lus = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    lus = 1'b1; br = 1'b1; req = 1'b1; rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dut_ctrl, halt} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want %b", {dut_ctrl, halt}, 6'b110000);
    end
    checks++;
    if ({stall_cycles, flush_count, memwait_cycles} !== {3*CNT_W{1'b0}}) begin
      errors++;
      $display("FAIL reset_cnt: got %h %h %h want 0", stall_cycles, flush_count, memwait_cycles);
    end
    @(negedge clk);
    lus = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
    rst_n = 1'b1;
  endtask

  // Rows: {lus, br, req, rdy}; idle, stall, branch+stall, same-cycle-ready access.
  task automatic test_idle_stall_branch();
    logic [3:0] pat [6] = '{4'b0000, 4'b1000, 4'b0000, 4'b1100, 4'b0100, 4'b1011};
    for (int i = 0; i < 6; i++) begin
      drive(pat[i][3], pat[i][2], pat[i][1], pat[i][0]);
      checks++;
      if ({dut_ctrl, halt} !== exp_out()) begin
        errors++;
        $display("FAIL basic[%0d]: got %b want %b", i, {dut_ctrl, halt}, exp_out());
      end
      model_step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({stall_cycles, flush_count, memwait_cycles} !== {m_stall, m_flush, m_memwait}) begin
      errors++;
      $display("FAIL basic_cnt: got %0d %0d %0d want %0d %0d %0d", stall_cycles, flush_count,
               memwait_cycles, m_stall, m_flush, m_memwait);
    end
    model_step();
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 6; i++) begin
      // Three frozen cycles with a branch and load-use pending, then release, then idle.
      if (i < 3)       drive(1'b1, 1'b1, 1'b1, 1'b0);
      else if (i == 3) drive(1'b1, 1'b1, 1'b1, 1'b1);
      else             drive(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({dut_ctrl, halt} !== exp_out()) begin
        errors++;
        $display("FAIL mem_wait[%0d]: got %b want %b", i, {dut_ctrl, halt}, exp_out());
      end
      model_step();
    end
    checks++;
    if ({stall_cycles, flush_count, memwait_cycles} !== {m_stall, m_flush, m_memwait}) begin
      errors++;
      $display("FAIL mem_wait_cnt: got %0d %0d %0d want %0d %0d %0d", stall_cycles, flush_count,
               memwait_cycles, m_stall, m_flush, m_memwait);
    end
  endtask

  task automatic test_timeout_boundary();
    // TO-1 frozen cycles, ready on the timeout cycle, then idle: must not halt.
    for (int i = 0; i < TO + 3; i++) begin
      if (i < TO - 1)       drive(1'b0, 1'b0, 1'b1, 1'b0);
      else if (i == TO - 1) drive(1'b0, 1'b0, 1'b1, 1'b1);
      else                  drive(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({dut_ctrl, halt} !== exp_out()) begin
        errors++;
        $display("FAIL to_boundary[%0d]: got %b want %b", i, {dut_ctrl, halt}, exp_out());
      end
      model_step();
    end
  endtask

  task automatic test_timeout_halt();
    for (int i = 0; i < TO + 5; i++) begin
      if (i < TO + 2) drive(1'b0, 1'b0, 1'b1, 1'b0);
      else            drive(1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({dut_ctrl, halt} !== exp_out()) begin
        errors++;
        $display("FAIL to_halt[%0d]: got %b want %b", i, {dut_ctrl, halt}, exp_out());
      end
      model_step();
    end
    // Asynchronous reset in mid-cycle must drop halt without waiting for a clock edge.
    @(negedge clk);
    req = 1'b1; rdy = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({dut_ctrl, halt} !== 6'b110000) begin
      errors++;
      $display("FAIL to_async_rst: got %b want %b", {dut_ctrl, halt}, 6'b110000);
    end
    @(negedge clk);
    lus = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    model_step();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    model_step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({dut_ctrl, halt} !== 6'b110000) begin
      errors++;
      $display("FAIL midwait_rst: got %b want %b", {dut_ctrl, halt}, 6'b110000);
    end
    @(negedge clk);
    lus = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
    rst_n = 1'b1;
    // A fresh wait needs the full timeout again.
    for (int i = 0; i < TO + 2; i++) begin
      if (i < TO) drive(1'b0, 1'b0, 1'b1, 1'b0);
      else        drive(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({dut_ctrl, halt} !== exp_out()) begin
        errors++;
        $display("FAIL midwait_fresh[%0d]: got %b want %b", i, {dut_ctrl, halt}, exp_out());
      end
      model_step();
    end
    do_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      if (m_halted && ($urandom_range(3) == 0)) do_reset();
      drive(1'($urandom_range(3) == 0), 1'($urandom_range(4) == 0),
            1'($urandom_range(1)), 1'($urandom_range(99) < 40));
      checks++;
      if ({dut_ctrl, halt} !== exp_out()) begin
        errors++;
        $display("FAIL random[%0d] in=%b%b%b%b: got %b want %b", i, lus, br, req, rdy,
                 {dut_ctrl, halt}, exp_out());
      end
      checks++;
      if ({stall_cycles, flush_count, memwait_cycles} !== {m_stall, m_flush, m_memwait}) begin
        errors++;
        $display("FAIL random_cnt[%0d]: got %0d %0d %0d want %0d %0d %0d", i, stall_cycles,
                 flush_count, memwait_cycles, m_stall, m_flush, m_memwait);
      end
      model_step();
    end
  endtask

  initial begin
    test_reset();
    test_idle_stall_branch();
    test_mem_wait();
    test_timeout_boundary();
    test_timeout_halt();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
